noc_packetizer: RTL and testbench
=================================

NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 SHALL have parameter WIDTH, default 128, flit width in bits.
REQ-002 SHALL have parameter N, default 16, number of NoC nodes; AW = $clog2(N).
REQ-003 SHALL have parameter NUM_VC, default 2, virtual channels; VCW = $clog2(NUM_VC).
REQ-004 SHALL have parameter VC_DEPTH, default 8, credits per VC after reset.
REQ-005 SHALL have parameter MAX_FLITS, default 4, maximum flits per packet; PW = WIDTH-3-VCW-AW, the payload bits per flit.
REQ-006 SHALL have port clk, input, 1, clock, all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port i_msg_valid, input, 1, message offered.
REQ-009 SHALL have port o_msg_ready, output, 1, message accepted when both this and i_msg_valid are high.
REQ-010 SHALL have port i_dest, input, AW, destination node.
REQ-011 SHALL have port i_num_flits, input, $clog2(MAX_FLITS+1), packet length.
REQ-012 SHALL have port i_data, input, MAX_FLITS*PW, payload; flit k carries bits [k*PW +: PW].
REQ-013 SHALL have port o_flit, output, WIDTH, flit to the NoC node port.
REQ-014 SHALL have port i_credit, input, NUM_VC, one-cycle credit return pulse per VC.
REQ-015 SHALL have port o_credit_err, output, 1, sticky credit-overflow flag.
REQ-016 SHALL have port o_pkt_count, output, 32, count of packets whose tail has been sent.

Function
REQ-017 Flit layout SHALL be as follows:
- bit WIDTH-1 is valid.
- bit WIDTH-2 is head.
- bit WIDTH-3 is tail.
- VC occupies [WIDTH-4 -: VCW].
- dest occupies [WIDTH-4-VCW -: AW].
- payload occupies [PW-1:0].
REQ-018 Every flit SHALL carry dest, not only the head flit.
REQ-019 o_flit SHALL be registered. It SHALL be all zeros in any cycle in which no flit is sent; o_flit is valid for exactly one cycle per flit.
REQ-020 The FSM SHALL have two states:
- IDLE: o_msg_ready=1.
- SEND: o_msg_ready=0.
REQ-021 In IDLE, a handshake SHALL latch i_dest, i_num_flits and i_data, clear the flit index, and move to SEND.
REQ-022 Length handling: i_num_flits=0 SHALL be treated as 1, and values above MAX_FLITS SHALL be clamped to MAX_FLITS.
REQ-023 Head VC selection: in SEND with flit index 0, the block SHALL pick the first VC with credit>0, searching from rr_ptr upward with wrap. If no VC has credit, it SHALL stall with no flit sent.
REQ-024 After a head flit is sent on VC v, rr_ptr SHALL become (v+1) mod NUM_VC. The packet SHALL then stay on VC v until its tail (wormhole).
REQ-025 Body and tail flits SHALL be sent only when credit[v]>0; otherwise the block SHALL stall, holding the flit index.
REQ-026 At most one flit SHALL be sent per cycle. A single-flit packet SHALL have head=1 and tail=1 in the same flit.
REQ-027 Latency: with a handshake at edge T and credit available, the head SHALL appear on o_flit after edge T+1. Subsequent flits SHALL appear on consecutive cycles while credit lasts.
REQ-028 On sending the tail, the block SHALL return to IDLE and increment o_pkt_count, which wraps at 2^32. This gives a minimum of one idle cycle between packets.
REQ-029 Credit counters (width $clog2(VC_DEPTH+1)):
- Each counter SHALL decrement on a send on that VC.
- Each counter SHALL increment on i_credit for that VC.
- A send and a credit on the same VC in the same cycle SHALL leave the counter unchanged.
REQ-030 A credit arriving when a counter already equals VC_DEPTH (with no send that cycle) SHALL set o_credit_err; the counter SHALL hold at VC_DEPTH.
REQ-031 Send eligibility SHALL use the counter value registered before the current cycle's credit pulse; a same-cycle credit does not unblock a stall.
REQ-032 i_msg_valid low in IDLE SHALL cause no state change. Inputs SHALL be ignored in SEND.

Reset
REQ-033 Reset SHALL force state=IDLE, o_msg_ready=1, o_flit=0, rr_ptr=0, all credit counters=VC_DEPTH, o_credit_err=0, o_pkt_count=0, flit index=0.
REQ-034 Reset asserted mid-packet SHALL abort the packet with no further flits; the first flit after reset SHALL be a head.

Verification
REQ-035 Single-flit packet (i_dest=5, i_num_flits=1) -> one flit with valid=1, head=1, tail=1, VC=0, dest=5, one cycle after the handshake; o_pkt_count=1.
REQ-036 4-flit packet (dest=3) -> flits on 4 consecutive cycles with head only on the first and tail only on the last; all on VC 0; payload slices 0..3 in order.
REQ-037 Credit exhaustion (VC_DEPTH=2, no credits returned, a 4-flit packet) -> 2 flits then stall. An i_credit[VC] pulse at cycle C -> the next flit at C+2.
REQ-038 Round-robin: two back-to-back 1-flit packets -> the first on VC 0, the second on VC 1. With VC 1 at 0 credits -> the second goes on VC 0.
REQ-039 Credit overflow: an i_credit pulse with the counter at VC_DEPTH -> o_credit_err=1 and stays high until reset.
REQ-040 Reset asserted after the 2nd flit of a 4-flit packet -> o_flit=0 immediately, counters=VC_DEPTH; the next message starts with a head flit on VC 0.

Source files
------------

// File: rtl/noc_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : noc_packetizer
// Purpose  : Splits a message into wormhole flits for a NoC node port. Each
//            flit carries {valid, head, tail, vc, dest, payload}. The head
//            flit picks a VC round-robin among VCs with credit, and the rest
//            of the packet stays on that VC. Per-VC credit counters gate
//            every flit.
// Ports    : clk, reset (async, active-high)
//            i_msg_valid / o_msg_ready      - message handshake
//            i_dest, i_num_flits, i_data    - message contents
//            o_flit                         - registered flit, zero when idle
//            i_credit                       - per-VC credit return pulses
//            o_credit_err                   - sticky credit-overflow flag
//            o_pkt_count                    - packets whose tail was sent
// Revision : 1.0 - initial release
// ============================================================================
module noc_packetizer #(
  parameter int WIDTH     = 128,
  parameter int N         = 16,
  parameter int NUM_VC    = 2,
  parameter int VC_DEPTH  = 8,
  parameter int MAX_FLITS = 4,
  localparam int AW  = $clog2(N),
  localparam int VCW = $clog2(NUM_VC),
  localparam int NFW = $clog2(MAX_FLITS + 1),
  localparam int PW  = WIDTH - 3 - VCW - AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_msg_valid,
  output logic                    o_msg_ready,
  input  logic [AW-1:0]           i_dest,
  input  logic [NFW-1:0]          i_num_flits,
  input  logic [MAX_FLITS*PW-1:0] i_data,
  output logic [WIDTH-1:0]        o_flit,
  input  logic [NUM_VC-1:0]       i_credit,
  output logic                    o_credit_err,
  output logic [31:0]             o_pkt_count
);

  localparam int CW   = $clog2(VC_DEPTH + 1);
  localparam int VCW1 = VCW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic [AW-1:0]                 dest_q, dest_d;
  logic [NFW-1:0]                nflits_q, nflits_d;
  logic [MAX_FLITS*PW-1:0]       data_q, data_d;
  logic [NFW-1:0]                idx_q, idx_d;
  logic [VCW-1:0]                vc_q, vc_d;
  logic [VCW-1:0]                rr_q, rr_d;
  logic [NUM_VC-1:0][CW-1:0]     credit_q, credit_d;
  logic                          credit_err_q, credit_err_d;
  logic [31:0]                   pkt_count_q, pkt_count_d;
  logic [WIDTH-1:0]              flit_q, flit_d;

  logic                    handshake;
  logic                    head_found;
  logic [VCW-1:0]          head_vc;
  logic [VCW-1:0]          cur_vc;
  logic                    send;
  logic                    is_head;
  logic                    is_tail;
  logic [NFW-1:0]          nf_in;
  logic [MAX_FLITS*PW-1:0] data_shift;
  logic [PW-1:0]           payload;

  assign handshake = (state_q == S_IDLE) && i_msg_valid;

  // Zero-length requests become one flit; oversize requests are clamped.
  always_comb begin
    nf_in = i_num_flits;
    if (i_num_flits == '0)
      nf_in = NFW'(1);
    else if (i_num_flits > NFW'(MAX_FLITS))
      nf_in = NFW'(MAX_FLITS);
  end

  // First VC with credit, searching upward from rr_q with wrap.
  always_comb begin
    logic [VCW:0] cand;
    head_found = 1'b0;
    head_vc    = rr_q;
    cand       = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      cand = {1'b0, rr_q} + VCW1'(i);
      if (cand >= VCW1'(NUM_VC))
        cand = cand - VCW1'(NUM_VC);
      if (!head_found && (credit_q[cand[VCW-1:0]] != '0)) begin
        head_found = 1'b1;
        head_vc    = cand[VCW-1:0];
      end
    end
  end

  // Eligibility uses the registered counters only, so a credit pulse in
  // this cycle cannot release a stall until the next one.
  assign is_head    = (idx_q == '0);
  assign is_tail    = (idx_q == nflits_q - NFW'(1));
  assign cur_vc     = is_head ? head_vc : vc_q;
  assign send       = (state_q == S_SEND) &&
                      (is_head ? head_found : (credit_q[vc_q] != '0));
  assign data_shift = data_q >> (32'(idx_q) * PW);
  assign payload    = data_shift[PW-1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_msg_valid) state_d = S_SEND;
      S_SEND:  if (send && is_tail) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_msg_ready = (state_q == S_IDLE);
  end

  // Datapath next values
  always_comb begin
    logic [VCW:0] rr_sum;
    logic         dec;
    dest_d       = dest_q;
    nflits_d     = nflits_q;
    data_d       = data_q;
    idx_d        = idx_q;
    vc_d         = vc_q;
    rr_d         = rr_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    pkt_count_d  = pkt_count_q;
    flit_d       = '0;
    rr_sum       = {1'b0, cur_vc} + VCW1'(1);
    dec          = 1'b0;

    if (handshake) begin
      dest_d   = i_dest;
      nflits_d = nf_in;
      data_d   = i_data;
      idx_d    = '0;
    end

    if (send) begin
      flit_d = {1'b1, is_head, is_tail, cur_vc, dest_q, payload};
      idx_d  = idx_q + NFW'(1);
      if (is_head) begin
        vc_d = cur_vc;
        rr_d = (rr_sum >= VCW1'(NUM_VC)) ? '0 : rr_sum[VCW-1:0];
      end
      if (is_tail) begin
        idx_d       = '0;
        pkt_count_d = pkt_count_q + 32'd1;
      end
    end

    // A send and a credit on the same VC cancel out.
    for (int v = 0; v < NUM_VC; v++) begin
      dec = send && (cur_vc == VCW'(v));
      if (i_credit[v] && !dec) begin
        if (credit_q[v] == CW'(VC_DEPTH))
          credit_err_d = 1'b1;
        else
          credit_d[v] = credit_q[v] + CW'(1);
      end else if (dec && !i_credit[v]) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q       <= '0;
      nflits_q     <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      vc_q         <= '0;
      rr_q         <= '0;
      credit_q     <= {NUM_VC{CW'(VC_DEPTH)}};
      credit_err_q <= 1'b0;
      pkt_count_q  <= '0;
      flit_q       <= '0;
    end else begin
      dest_q       <= dest_d;
      nflits_q     <= nflits_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      vc_q         <= vc_d;
      rr_q         <= rr_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      pkt_count_q  <= pkt_count_d;
      flit_q       <= flit_d;
    end
  end

  assign o_flit       = flit_q;
  assign o_credit_err = credit_err_q;
  assign o_pkt_count  = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_packetizer
// Purpose  : Directed and randomized checks of noc_packetizer against a
//            transaction-level reference model (integer credit counts, a
//            latched message and a flit cursor).
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_packetizer;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int NV    = 2;
  localparam int VD    = 2;
  localparam int MF    = 4;
  localparam int PW    = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_msg_valid = 1'b0;
  logic          o_msg_ready;
  logic [3:0]    i_dest = '0;
  logic [2:0]    i_num_flits = '0;
  logic [95:0]   i_data = '0;
  logic [31:0]   o_flit;
  logic [1:0]    i_credit = '0;
  logic          o_credit_err;
  logic [31:0]   o_pkt_count;

  noc_packetizer #(
    .WIDTH(WIDTH), .N(N), .NUM_VC(NV), .VC_DEPTH(VD), .MAX_FLITS(MF)
  ) dut (
    .clk(clk), .reset(reset),
    .i_msg_valid(i_msg_valid), .o_msg_ready(o_msg_ready),
    .i_dest(i_dest), .i_num_flits(i_num_flits), .i_data(i_data),
    .o_flit(o_flit), .i_credit(i_credit),
    .o_credit_err(o_credit_err), .o_pkt_count(o_pkt_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  int          cred [NV];
  int          rr;
  bit          busy;
  int          idx, nf, pvc;
  logic [3:0]  mdest;
  logic [23:0] mpl [MF];
  bit          err;
  int unsigned pkts;
  logic [31:0] exp_flit;

  // credit sink: 0 = manual pulses only, 1 = return next cycle, 2 = random
  int          sink_mode = 0;
  int          pend [NV];
  logic [1:0]  man_cr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin cred[v] = VD; pend[v] = 0; end
    rr = 0; busy = 0; idx = 0; nf = 0; pvc = 0; err = 0; pkts = 0;
    exp_flit = '0;
  endtask

  // Predict what the DUT registers at the coming edge.
  task automatic model_edge();
    int pre [NV];
    int sv, v, net;
    bit h, t;
    logic [31:0] f;
    f  = '0;
    sv = -1;
    for (int k = 0; k < NV; k++) pre[k] = cred[k];
    if (busy) begin
      if (idx == 0) begin
        for (int k = 0; k < NV; k++) begin
          v = (rr + k) % NV;
          if (sv < 0 && pre[v] > 0) sv = v;
        end
      end else if (pre[pvc] > 0) begin
        sv = pvc;
      end
      if (sv >= 0) begin
        h = (idx == 0);
        t = (idx == nf - 1);
        f = {1'b1, h, t, 1'(sv), mdest, mpl[idx]};
        if (h) begin pvc = sv; rr = (sv + 1) % NV; end
        idx++;
        if (t) begin busy = 0; pkts++; end
      end
    end else if (i_msg_valid) begin
      mdest = i_dest;
      for (int k = 0; k < MF; k++) mpl[k] = i_data[k*PW +: PW];
      nf = int'(i_num_flits);
      if (nf == 0) nf = 1;
      if (nf > MF) nf = MF;
      idx  = 0;
      busy = 1;
    end
    for (int k = 0; k < NV; k++) begin
      net = (i_credit[k] ? 1 : 0) - ((sv == k) ? 1 : 0);
      if (net > 0 && pre[k] == VD) err = 1;
      else cred[k] = pre[k] + net;
    end
    exp_flit = f;
  endtask

  // One clock: drive credits, predict, clock, compare.
  task automatic step();
    logic [1:0] cr;
    cr = man_cr;
    for (int v = 0; v < NV; v++) begin
      if (pend[v] > 0 && (sink_mode == 1 || (sink_mode == 2 && $urandom_range(0, 1) == 1))) begin
        cr[v] = 1'b1;
        pend[v]--;
      end
    end
    i_credit = cr;
    model_edge();
    @(posedge clk);
    #1;
    if (exp_flit[31]) pend[exp_flit[28]]++;
    chk("flit", 64'(o_flit), 64'(exp_flit));
    chk("ready", 64'(o_msg_ready), 64'(!busy));
    chk("pkt_count", 64'(o_pkt_count), 64'(pkts));
    chk("credit_err", 64'(o_credit_err), 64'(err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_msg(input logic [3:0] d, input logic [2:0] n, input logic [95:0] data);
    i_msg_valid = 1'b1;
    i_dest      = d;
    i_num_flits = n;
    i_data      = data;
    step();
    i_msg_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_flit", 64'(o_flit), 64'd0);
    chk("rst_ready", 64'(o_msg_ready), 64'd1);
    chk("rst_count", 64'(o_pkt_count), 64'd0);
    chk("rst_err", 64'(o_credit_err), 64'd0);
  endtask

  initial begin
    logic [95:0] rd;
    int guard;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // single-flit packet to node 5
    sink_mode = 1;
    send_msg(4'd5, 3'd1, 96'h0000_0000_0000_0000_00AB_CDEF);
    step();
    chk("single_hdr", 64'(o_flit[31:24]), 64'hE5);
    chk("single_payload", 64'(o_flit[23:0]), 64'hABCDEF);
    chk("single_count", 64'(o_pkt_count), 64'd1);
    run(3);

    // 4-flit packet to node 3 from a clean reset
    do_reset();
    send_msg(4'd3, 3'd4, 96'h333333_222222_111111_000000);
    step();
    chk("p4_head", 64'(o_flit[31:24]), 64'hC3);
    run(2);
    step();
    chk("p4_tail", 64'(o_flit[31:24]), 64'hA3);
    chk("p4_last_payload", 64'(o_flit[23:0]), 64'h333333);
    run(3);

    // credit exhaustion then single credit pulses
    do_reset();
    sink_mode = 0;
    send_msg(4'd9, 3'd4, {$urandom, $urandom, $urandom});
    run(5);
    man_cr = 2'b01;
    step();
    man_cr = 2'b00;
    step();
    chk("stall_release", 64'(o_flit[31]), 64'd1);
    run(2);
    man_cr = 2'b01;
    step();
    man_cr = 2'b00;
    run(3);

    // round-robin across back-to-back packets
    do_reset();
    sink_mode = 1;
    send_msg(4'd1, 3'd1, {$urandom, $urandom, $urandom});
    step();
    chk("rr_first_vc", 64'(o_flit[28]), 64'd0);
    send_msg(4'd2, 3'd0, {$urandom, $urandom, $urandom});
    step();
    chk("rr_second_vc", 64'(o_flit[28]), 64'd1);
    run(3);

    // VC 1 drained: the pointer lands on VC 1 but the packet takes VC 0
    do_reset();
    sink_mode = 0;
    for (int p = 0; p < 4; p++) begin
      send_msg(4'(p), 3'd1, {$urandom, $urandom, $urandom});
      step();
    end
    man_cr = 2'b01; step(); step(); man_cr = 2'b00;
    send_msg(4'd6, 3'd1, {$urandom, $urandom, $urandom});
    step();
    send_msg(4'd7, 3'd1, {$urandom, $urandom, $urandom});
    step();
    chk("rr_skip_vc", 64'(o_flit[31:24]), 64'hE7);
    run(2);

    // credit overflow is sticky until reset
    do_reset();
    man_cr = 2'b10;
    step();
    man_cr = 2'b00;
    chk("ovf_set", 64'(o_credit_err), 64'd1);
    run(4);
    chk("ovf_sticky", 64'(o_credit_err), 64'd1);

    // reset in the middle of a 4-flit packet
    do_reset();
    sink_mode = 1;
    send_msg(4'd4, 3'd4, {$urandom, $urandom, $urandom});
    run(2);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_flit", 64'(o_flit), 64'd0);
    chk("midrst_ready", 64'(o_msg_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_msg(4'd8, 3'd2, {$urandom, $urandom, $urandom});
    step();
    chk("midrst_head", 64'(o_flit[31:28]), 64'hC);
    run(3);

    // randomized traffic with a randomly paced credit sink
    sink_mode = 2;
    for (int m = 0; m < 40; m++) begin
      guard = 0;
      while (busy && guard < 200) begin
        i_msg_valid = 1'($urandom_range(0, 1));
        i_dest      = 4'($urandom);
        i_num_flits = 3'($urandom);
        step();
        guard++;
      end
      i_msg_valid = 1'b0;
      run($urandom_range(0, 2));
      rd = {$urandom, $urandom, $urandom};
      send_msg(4'($urandom), 3'($urandom_range(0, 7)), rd);
    end
    sink_mode = 1;
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
